// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: round-robin grant of one shared datapath among four requesters,
// holding each grant until done/withdrawal, with a watchdog abort for hung transactions.
module shared_port_arbiter #(
   parameter int TIMEOUT  = 16,
   parameter int CNT_BITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] select,
   output logic       busy,
   output logic       timeout
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [1:0] ptr, ptr_n, select_n, rel_ptr, base, win;
   logic [3:0] grant_n;
   logic [CNT_BITS-1:0] cnt, cnt_n;
   logic busy_n, timeout_n, release_now;
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction
   assign rel_ptr     = select + 2'd1;
   assign base        = (state == IDLE) ? ptr : rel_ptr;
   assign win         = pick(req, base);
   assign release_now = done || !req[select];
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      grant_n   = grant;
      select_n  = select;
      busy_n    = busy;
      timeout_n = 1'b0;
      if (state == IDLE) begin
         if (|req) begin
            grant_n  = 4'b0001 << win;
            select_n = win;
            busy_n   = 1'b1;
            cnt_n    = '0;
            state_n  = BUSY;
         end
      end else if (release_now) begin
         ptr_n   = rel_ptr;
         cnt_n   = '0;
         grant_n = (|req) ? (4'b0001 << win) : 4'b0000;
         select_n = (|req) ? win : select;
         busy_n  = |req;
         state_n = (|req) ? BUSY : IDLE;
      end else if (cnt == CNT_BITS'(TIMEOUT - 1)) begin
         // abort always passes through IDLE, guaranteeing one empty cycle
         timeout_n = 1'b1;
         ptr_n     = rel_ptr;
         cnt_n     = '0;
         grant_n   = 4'b0000;
         busy_n    = 1'b0;
         state_n   = IDLE;
      end else begin
         cnt_n = cnt + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         cnt     <= '0;
         grant   <= 4'b0000;
         select  <= 2'd0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         grant   <= grant_n;
         select  <= select_n;
         busy    <= busy_n;
         timeout <= timeout_n;
      end
   end
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter: directed scenarios for the round-robin shared-port arbiter.
module tb_shared_port_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic [1:0] select;
   logic       busy;
   logic       timeout;
   int nvec = 0;
   int nerr = 0;

   shared_port_arbiter #(.TIMEOUT(4), .CNT_BITS(8)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .select(select), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req  = 4'b0000;
      done = 1'b0;
      rst  = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if ({grant, select, busy, timeout} !== 8'b0) begin
         nerr++;
         $display("FAIL reset: got g=%b s=%0d b=%b t=%b want all zero", grant, select, busy, timeout);
      end
   endtask

   task automatic test_alternate();
      logic [3:0] exp_g [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      logic [1:0] exp_s [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
      do_reset();
      req  = 4'b0101;
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         nvec++;
         if ({grant, select, busy, timeout} !== {exp_g[i], exp_s[i], 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL alternate[%0d]: got g=%b s=%0d b=%b t=%b want g=%b s=%0d b=1 t=0",
                     i, grant, select, busy, timeout, exp_g[i], exp_s[i]);
         end
      end
   endtask

   task automatic test_rotate();
      logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111;
      step();
      for (int j = 0; j < 5; j++) begin
         for (int c = 0; c < 3; c++) begin
            nvec++;
            if ({grant, busy, timeout} !== {exp_g[j], 1'b1, 1'b0}) begin
               nerr++;
               $display("FAIL rotate[%0d.%0d]: got g=%b b=%b t=%b want g=%b b=1 t=0",
                        j, c, grant, busy, timeout, exp_g[j]);
            end
            done = (c == 2);
            step();
         end
      end
      done = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         step();
         nvec++;
         if ({grant, select, busy, timeout} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL timeout_hold[%0d]: got g=%b s=%0d b=%b t=%b want g=0010 s=1 b=1 t=0",
                     i, grant, select, busy, timeout);
         end
      end
      step();
      nvec++;
      if ({grant, busy, timeout} !== {4'b0000, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL timeout_abort: got g=%b b=%b t=%b want g=0000 b=0 t=1", grant, busy, timeout);
      end
      step();
      nvec++;
      if ({grant, select, busy, timeout} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL timeout_regrant: got g=%b s=%0d b=%b t=%b want g=0010 s=1 b=1 t=0",
                  grant, select, busy, timeout);
      end
   endtask

   task automatic test_done_beats_timeout();
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 4; i++) step();
      nvec++;
      if ({grant, timeout} !== {4'b0001, 1'b0}) begin
         nerr++;
         $display("FAIL done_vs_wd_pre: got g=%b t=%b want g=0001 t=0", grant, timeout);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      nvec++;
      if ({grant, select, busy, timeout} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL done_vs_wd: got g=%b s=%0d b=%b t=%b want g=0010 s=1 b=1 t=0",
                  grant, select, busy, timeout);
      end
   endtask

   task automatic test_withdraw_wrap();
      do_reset();
      req = 4'b1000;
      step();
      nvec++;
      if ({grant, select, busy} !== {4'b1000, 2'd3, 1'b1}) begin
         nerr++;
         $display("FAIL wrap_grant3: got g=%b s=%0d b=%b want g=1000 s=3 b=1", grant, select, busy);
      end
      req = 4'b0001;
      step();
      nvec++;
      if ({grant, select, busy, timeout} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL wrap_withdraw: got g=%b s=%0d b=%b t=%b want g=0001 s=0 b=1 t=0",
                  grant, select, busy, timeout);
      end
      req = 4'b0000;
      step();
      nvec++;
      if ({grant, select, busy} !== {4'b0000, 2'd0, 1'b0}) begin
         nerr++;
         $display("FAIL empty_release: got g=%b s=%0d b=%b want g=0000 s=0 b=0", grant, select, busy);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      step();
      nvec++;
      if ({grant, select, busy} !== {4'b0100, 2'd2, 1'b1}) begin
         nerr++;
         $display("FAIL areset_pre: got g=%b s=%0d b=%b want g=0100 s=2 b=1", grant, select, busy);
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({grant, select, busy, timeout} !== 8'b0) begin
         nerr++;
         $display("FAIL areset_mid: got g=%b s=%0d b=%b t=%b want all zero", grant, select, busy, timeout);
      end
      req = 4'b1000;
      rst = 1'b0;
      step();
      nvec++;
      if ({grant, select, busy, timeout} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL areset_after: got g=%b s=%0d b=%b t=%b want g=1000 s=3 b=1 t=0",
                  grant, select, busy, timeout);
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_rotate();
      test_timeout();
      test_done_beats_timeout();
      test_withdraw_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/shared_port_arbiter.md
Name: shared_port_arbiter

Overview:
- Round-robin scheduler that shares one 4-input datapath resource among four requesters, e.g. the unified memory port that four_to_one_mux instances feed.
- Issues a one-hot grant and drives the 2-bit mux select.
- Holds each grant across a multi-cycle transaction until the resource signals done.
- Recovers from a hung transaction with a watchdog timeout.

Parameters:
- TIMEOUT, 16: maximum cycles a grant may be held without done. Legal range 2..255.
- CNT_BITS, 8: width of the watchdog counter. Must satisfy 2^CNT_BITS > TIMEOUT.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 4: request per requester; bit i = requester i.
- done, input, 1: resource completed the current transaction; sampled only in BUSY.
- grant, output, 4: one-hot grant, registered; all zero when idle.
- select, output, 2: binary index of granted requester, drives the mux select; registered.
- busy, output, 1: high while any grant is active.
- timeout, output, 1: single-cycle pulse when the watchdog aborts a grant.

Behaviour:
- All outputs are registered. No combinational path from req or done to any output.
- Reset (asynchronous, effective immediately): grant=0, select=0, busy=0, timeout=0, state=IDLE, ptr=0, cnt=0.
  - Reset asserted mid-transaction drops the grant with no timeout pulse.
- State IDLE:
  - If req!=0: winner = first i in order ptr, ptr+1, ..., ptr+3 (mod 4) with req[i]=1.
  - Next cycle: grant=1<<winner, select=winner, busy=1, cnt=0, state→BUSY.
  - Latency from req rising to grant is 1 cycle.
  - done is ignored in IDLE.
- State BUSY, evaluated each cycle with g = current winner:
  - Priority 1, release: done=1 OR req[g]=0 (requester withdrew). Set ptr=(g+1) mod 4, then re-arbitrate immediately among req using the new ptr. The current requester may win again only if no other bit of req is set.
    - If the re-arbitration finds a winner: grant switches to the new one-hot value next cycle, busy stays 1, cnt=0. Back-to-back grants with no bubble.
    - If req is empty: next cycle grant=0, busy=0, state→IDLE. select retains the last granted index.
  - Priority 2, watchdog: else if cnt==TIMEOUT-1, abort. timeout=1 for exactly one cycle, coincident with the cycle grant becomes 0. Then ptr=(g+1) mod 4, grant=0, busy=0, state→IDLE. No same-cycle re-grant after a timeout; one idle cycle is guaranteed.
  - Priority 3: else cnt+1; grant and select unchanged.
  - done and cnt==TIMEOUT-1 in the same cycle: done wins, no timeout pulse.
- Invariants:
  - grant is always one-hot or zero.
  - select equals log2(grant) whenever grant!=0.
  - busy == (grant!=0).
  - grant never changes in BUSY unless a release or timeout occurs.
- ptr wraps 3→0. Fairness bound: a continuously requesting requester is granted within 3 other transactions.
- The watchdog counter saturates only via the abort. It never wraps.
- A req bit asserted for a non-granted requester during BUSY is queued implicitly: it is considered at the next release.

Test Plan:
- Reset then req=4'b0101 held, done pulsed 1 cycle after each grant:
  - grant sequence 0001, 0100, 0001, 0100.
  - select 0, 2, 0, 2.
  - Each switch occurs the cycle after done, no idle gap.
- req=4'b1111 held, done every 3rd cycle: grants rotate 0001→0010→0100→1000→0001. Each grant lasts exactly 3 cycles; busy stays 1 throughout.
- TIMEOUT=4, req=4'b0010 held, done never:
  - grant=0010 for 4 cycles.
  - Then grant=0, busy=0, timeout=1 for 1 cycle.
  - Next cycle grant=0010 again (ptr=2, only requester 1 pending).
- TIMEOUT=4, done asserted on the same cycle cnt==3: no timeout pulse; normal release and re-arbitration.
- Grant to requester 3 active, req[3] deasserted, req=4'b0001: next cycle grant=0001, select=0, ptr wraps 3→0.
- Grant active for requester 2, rst asserted asynchronously between clock edges: grant, busy, select and timeout all 0 before the next edge. After release, req=4'b1000 gives grant=1000 one cycle later (ptr=0).
